// File: rtl/uart_tx_ctrl_if.sv
// Host-write and serializer handshake bundle for uart_tx_ctrl.
// slave is the controller's view; master is the host/serializer view.
interface uart_tx_ctrl_if;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       wr_ready;
   logic       send;
   logic [7:0] tx_data;
   logic       parity_bit;
   logic       ser_active;

   modport slave (
      input  wr_en, wr_data, ser_active,
      output wr_ready, send, tx_data, parity_bit
   );

   modport master (
      output wr_en, wr_data, ser_active,
      input  wr_ready, send, tx_data, parity_bit
   );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit front-end: byte FIFO feeding a serializer through a send/ser_active
// handshake, with parity generation, start timeout and sticky error flags.
//
//   state | meaning
//   IDLE  | no frame in flight; launches when tx_enable=1 and the FIFO is non-empty
//   SEND  | send held high, waiting for the serializer to report active
//   BUSY  | serializer shifting the frame; waiting for ser_active to fall
module uart_tx_ctrl #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                     baud_clk,
   input  logic                     reset_n,
   uart_tx_ctrl_if.slave            bus,
   input  logic                     tx_enable,
   input  logic                     parity_en,
   input  logic                     parity_odd,
   input  logic                     err_clr,
   output logic                     fifo_empty,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     busy,
   output logic                     overflow_err,
   output logic                     start_err
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, SEND, BUSY} state_t;

   state_t         state, state_nxt;
   logic [7:0]     mem [DEPTH];
   logic [PW-1:0]  rd_ptr, wr_ptr;
   logic [CW-1:0]  count;
   logic [3:0]     timer;
   logic           launch, push, drop, timeout_hit;
   logic           send_q, parity_q;
   logic [7:0]     tx_data_q;
   logic [7:0]     head;

   assign head = mem[rd_ptr];

   always_comb begin
      state_nxt   = state;
      timeout_hit = 1'b0;
      case (state)
         IDLE: if (tx_enable && (count != '0)) state_nxt = SEND;
         SEND: begin
            if (bus.ser_active) begin
               state_nxt = BUSY;
            end else if (timer == 4'(TIMEOUT - 1)) begin
               // timer counts SEND cycles already spent, so send stays high TIMEOUT cycles
               state_nxt   = IDLE;
               timeout_hit = 1'b1;
            end
         end
         BUSY: if (!bus.ser_active) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign launch = (state == IDLE) && (state_nxt == SEND);
   assign push   = bus.wr_en && ((count != CW'(DEPTH)) || launch);
   assign drop   = bus.wr_en && !push;

   always_ff @(posedge baud_clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         timer      <= 4'd0;
         send_q     <= 1'b0;
         tx_data_q  <= 8'h00;
         parity_q   <= 1'b1;
      end else begin
         state  <= state_nxt;
         send_q <= (state_nxt == SEND);
         if (launch) timer <= 4'd0;
         else if (state == SEND) timer <= timer + 4'd1;
         // Parity inputs are captured only here, so later changes cannot disturb the frame.
         if (launch) begin
            tx_data_q <= head;
            parity_q  <= parity_en ? ((^head) ^ parity_odd) : 1'b1;
         end
      end
   end

   always_ff @(posedge baud_clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + 1'b1;
         if (launch) rd_ptr <= rd_ptr + 1'b1;
         case ({push, launch})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge baud_clk) begin
      if (push) mem[wr_ptr] <= bus.wr_data;
   end

   // A flag-setting event in the same cycle as err_clr wins.
   always_ff @(posedge baud_clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow_err <= 1'b0;
         start_err    <= 1'b0;
      end else begin
         if (drop)         overflow_err <= 1'b1;
         else if (err_clr) overflow_err <= 1'b0;
         if (timeout_hit)  start_err <= 1'b1;
         else if (err_clr) start_err <= 1'b0;
      end
   end

   assign bus.send       = send_q;
   assign bus.tx_data    = tx_data_q;
   assign bus.parity_bit = parity_q;
   assign bus.wr_ready   = (count != CW'(DEPTH));
   assign fifo_empty     = (count == '0);
   assign fifo_count     = count;
   assign busy           = (state != IDLE);
endmodule
